// File: rtl/instr_dispatch.sv
// Instruction dispatcher: latches a 16-bit instruction, decodes the opcode to one of
// six sub-FSMs, pulses its start bit and waits for its done. DISPATCH_TIMEOUT_EN adds a WAIT watchdog.
module instr_dispatch #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instruction,
  output logic [3:0]  opcode,
  output logic [5:0]  param1,
  output logic [5:0]  param2,
  output logic [5:0]  fsm_start,
  input  logic [5:0]  fsm_done,
  output logic        busy,
  output logic        instr_done,
  output logic        timeout_err
);

  typedef enum logic [2:0] {IDLE, DECODE, START, WAIT, DONE} state_t;

  state_t      state_reg;
  logic [5:0]  sel_reg;
  logic [5:0]  fsm_start_reg;
  logic [3:0]  opcode_reg;
  logic [5:0]  param1_reg;
  logic [5:0]  param2_reg;
  logic        instr_ready_reg;
  logic        busy_reg;
  logic        instr_done_reg;
  logic        done_hit;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("instr_dispatch: TIMEOUT_CYCLES must be in 1..255");
  end

  // 0x0-0x7 ALU, 0x8-0xB ALUI, 0xC..0xF map onto bits 2..5 in order.
  function automatic logic [5:0] decode_sel(input logic [3:0] op);
    logic [5:0] sel;
    sel = 6'b000000;
    if (!op[3])
      sel = 6'b000001;
    else if (op[3:2] == 2'b10)
      sel = 6'b000010;
    else
      sel = 6'b000100 << op[1:0];
    return sel;
  endfunction

  assign done_hit = |(fsm_done & sel_reg);

`ifdef DISPATCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] count_reg;
  logic [7:0] count_next;
  logic       timeout_err_reg;

  assign count_next  = count_reg + 8'd1;
  assign timeout_err = timeout_err_reg;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg       <= IDLE;
      sel_reg         <= 6'b000000;
      fsm_start_reg   <= 6'b000000;
      opcode_reg      <= 4'h0;
      param1_reg      <= 6'h00;
      param2_reg      <= 6'h00;
      instr_ready_reg <= 1'b1;
      busy_reg        <= 1'b0;
      instr_done_reg  <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
      count_reg       <= 8'd0;
      timeout_err_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (instr_valid) begin
            opcode_reg      <= instruction[15:12];
            param1_reg      <= instruction[11:6];
            param2_reg      <= instruction[5:0];
            instr_ready_reg <= 1'b0;
            busy_reg        <= 1'b1;
            state_reg       <= DECODE;
          end
        end
        DECODE: begin
          sel_reg       <= decode_sel(opcode_reg);
          fsm_start_reg <= decode_sel(opcode_reg);
          state_reg     <= START;
        end
        START: begin
          // Done is deliberately not looked at here; sampling starts in WAIT.
          fsm_start_reg <= 6'b000000;
`ifdef DISPATCH_TIMEOUT_EN
          count_reg     <= 8'd0;
`endif
          state_reg     <= WAIT;
        end
        WAIT: begin
          if (done_hit) begin
            instr_done_reg <= 1'b1;
            state_reg      <= DONE;
          end
`ifdef DISPATCH_TIMEOUT_EN
          else if (count_next == TIMEOUT_LIMIT) begin
            instr_done_reg  <= 1'b1;
            timeout_err_reg <= 1'b1;
            state_reg       <= DONE;
          end else begin
            count_reg <= count_next;
          end
`endif
        end
        DONE: begin
          instr_done_reg  <= 1'b0;
          busy_reg        <= 1'b0;
          instr_ready_reg <= 1'b1;
          state_reg       <= IDLE;
        end
        default: begin
          fsm_start_reg   <= 6'b000000;
          instr_done_reg  <= 1'b0;
          busy_reg        <= 1'b0;
          instr_ready_reg <= 1'b1;
          state_reg       <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready = instr_ready_reg;
  assign opcode      = opcode_reg;
  assign param1      = param1_reg;
  assign param2      = param2_reg;
  assign fsm_start   = fsm_start_reg;
  assign busy        = busy_reg;
  assign instr_done  = instr_done_reg;

endmodule

// File: tb/tb_instr_dispatch.sv
// Directed bench for instr_dispatch; with DISPATCH_TIMEOUT_EN a second instance
// (TIMEOUT_CYCLES=4) shares the stimulus and exercises the watchdog.
module tb_instr_dispatch;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instruction;
  logic [5:0]  fsm_done;
  logic        instr_ready;
  logic [3:0]  opcode;
  logic [5:0]  param1;
  logic [5:0]  param2;
  logic [5:0]  fsm_start;
  logic        busy;
  logic        instr_done;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  instr_dispatch dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .opcode(opcode), .param1(param1), .param2(param2),
    .fsm_start(fsm_start), .fsm_done(fsm_done), .busy(busy), .instr_done(instr_done),
    .timeout_err(timeout_err)
  );

`ifdef DISPATCH_TIMEOUT_EN
  logic        t_instr_ready;
  logic [3:0]  t_opcode;
  logic [5:0]  t_param1;
  logic [5:0]  t_param2;
  logic [5:0]  t_fsm_start;
  logic        t_busy;
  logic        t_instr_done;
  logic        t_timeout_err;

  instr_dispatch #(.TIMEOUT_CYCLES(4)) dut_to (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(t_instr_ready),
    .instruction(instruction), .opcode(t_opcode), .param1(t_param1), .param2(t_param2),
    .fsm_start(t_fsm_start), .fsm_done(fsm_done), .busy(t_busy), .instr_done(t_instr_done),
    .timeout_err(t_timeout_err)
  );
`endif

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
      $display("[TB] %s ok obs=%h", tag, obs);
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; instr_valid = 1'b0; instruction = 16'h0000; fsm_done = 6'b0;
    tick(); tick(); tick();
    chk("rst_fsm_start", 16'(fsm_start), 16'h0);
    chk("rst_opcode", 16'(opcode), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_instr_done", 16'(instr_done), 16'h0);
    chk("rst_timeout_err", 16'(timeout_err), 16'h0);
    reset = 1'b1;
    tick();
    chk("rel_instr_ready", 16'(instr_ready), 16'h1);

    // 0x3456 -> ALU, done one cycle after start
    instruction = 16'h3456; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("a_opcode", 16'(opcode), 16'h3);
    chk("a_param1", 16'(param1), 16'h11);
    chk("a_param2", 16'(param2), 16'h16);
    chk("a_busy", 16'(busy), 16'h1);
    chk("a_ready_low", 16'(instr_ready), 16'h0);
    chk("a_start_decode", 16'(fsm_start), 16'h0);
    tick();
    chk("a_start", 16'(fsm_start), 16'h01);
    tick();
    chk("a_start_off", 16'(fsm_start), 16'h0);
    chk("a_no_done_yet", 16'(instr_done), 16'h0);
    fsm_done = 6'b000001;
    tick();
    fsm_done = 6'b0;
    chk("a_instr_done", 16'(instr_done), 16'h1);
    tick();
    chk("a_done_pulse_end", 16'(instr_done), 16'h0);
    chk("a_idle_busy", 16'(busy), 16'h0);
    chk("a_idle_ready", 16'(instr_ready), 16'h1);

    // 0xF041 -> LOAD, stray done[2] while waiting, done[5] after 10 cycles
    instruction = 16'hF041; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("b_opcode", 16'(opcode), 16'hF);
    chk("b_param1", 16'(param1), 16'h01);
    chk("b_param2", 16'(param2), 16'h01);
    tick();
    chk("b_start", 16'(fsm_start), 16'h20);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("b_wait_no_done", 16'(instr_done), 16'h0);
      chk("b_wait_busy", 16'(busy), 16'h1);
      fsm_done = (i == 3 || i == 4) ? 6'b000100 : 6'b000000;
    end
    fsm_done = 6'b100000;
    tick();
    fsm_done = 6'b0;
    chk("b_instr_done", 16'(instr_done), 16'h1);
    tick();
    chk("b_single_pulse", 16'(instr_done), 16'h0);
    tick();
    chk("b_still_quiet", 16'(instr_done), 16'h0);
    chk("b_timeout_err", 16'(timeout_err), 16'h0);

    // back-to-back 0xC000 then 0xD000 with valid held
    instruction = 16'hC000; instr_valid = 1'b1;
    tick();
    instruction = 16'hD000;
    chk("c_opcode_move", 16'(opcode), 16'hC);
    tick();
    chk("c_start_move", 16'(fsm_start), 16'h04);
    chk("c_held_off", 16'(opcode), 16'hC);
    tick();
    fsm_done = 6'b000100;
    tick();
    fsm_done = 6'b0;
    chk("c_move_done", 16'(instr_done), 16'h1);
    tick();
    chk("c_ready_back", 16'(instr_ready), 16'h1);
    chk("c_opcode_hold", 16'(opcode), 16'hC);
    tick();
    instr_valid = 1'b0;
    chk("c_opcode_movi", 16'(opcode), 16'hD);
    tick();
    chk("c_start_movi", 16'(fsm_start), 16'h08);
    tick();
    fsm_done = 6'b001000;
    tick();
    fsm_done = 6'b0;
    chk("c_movi_done", 16'(instr_done), 16'h1);
    tick();

    // 0x8000 -> ALUI, done[1] already high during START
    instruction = 16'h8000; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("d_start", 16'(fsm_start), 16'h02);
    fsm_done = 6'b000010;
    tick();
    chk("d_start_ignored", 16'(instr_done), 16'h0);
    tick();
    fsm_done = 6'b0;
    chk("d_wait_sample", 16'(instr_done), 16'h1);
    tick();

    // reset held two cycles mid-WAIT
    instruction = 16'h1000; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick(); tick();
    chk("e_in_wait", 16'(busy), 16'h1);
    reset = 1'b0;
    tick(); tick();
    chk("e_rst_busy", 16'(busy), 16'h0);
    chk("e_rst_start", 16'(fsm_start), 16'h0);
    chk("e_rst_done", 16'(instr_done), 16'h0);
    reset = 1'b1;
    fsm_done = 6'b000001;
    tick();
    fsm_done = 6'b0;
    chk("e_ready", 16'(instr_ready), 16'h1);
    chk("e_opcode_clr", 16'(opcode), 16'h0);
    tick();
    chk("e_no_pulse", 16'(instr_done), 16'h0);
    chk("e_idle_busy", 16'(busy), 16'h0);

`ifdef DISPATCH_TIMEOUT_EN
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    // done in the fourth WAIT cycle beats the watchdog
    instruction = 16'h0000; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("t_win_pending", 16'(t_instr_done), 16'h0);
    fsm_done = 6'b000001;
    tick();
    fsm_done = 6'b0;
    chk("t_win_done", 16'(t_instr_done), 16'h1);
    chk("t_win_no_err", 16'(t_timeout_err), 16'h0);
    tick();
    // no done: abort after four WAIT cycles
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("t_abort_pending", 16'(t_instr_done), 16'h0);
    tick();
    chk("t_abort_done", 16'(t_instr_done), 16'h1);
    chk("t_abort_err", 16'(t_timeout_err), 16'h1);
    tick();
    chk("t_abort_pulse_end", 16'(t_instr_done), 16'h0);
    // next normal instruction keeps the sticky flag
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick(); tick();
    fsm_done = 6'b000001;
    tick();
    fsm_done = 6'b0;
    chk("t_normal_done", 16'(t_instr_done), 16'h1);
    chk("t_err_sticky", 16'(t_timeout_err), 16'h1);
    reset = 1'b0;
    tick();
    chk("t_err_cleared", 16'(t_timeout_err), 16'h0);
    reset = 1'b1;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
